// File: rtl/chaining_pkg.sv
// Shared types and constants for the chaining write-hazard record table.
package chaining_pkg;

  localparam int VREG_W     = 5;
  localparam int MASK_W     = 16;
  localparam int INST_IDX_W = 3;
  localparam int GROUP_W    = $clog2(MASK_W);

  // One in-flight instruction as seen by the write checkers.
  typedef struct packed {
    logic                  vd_valid;
    logic [VREG_W-1:0]     vd_bits;
    logic                  vs1_valid;
    logic [VREG_W-1:0]     vs1_bits;
    logic [VREG_W-1:0]     vs2;
    logic [INST_IDX_W-1:0] instIndex;
    logic                  gather;
    logic                  gather16;
    logic                  onlyRead;
    logic [MASK_W-1:0]     elementMask;
  } record_t;

  // One-hot mask bit for a finished element group.
  function automatic logic [MASK_W-1:0] group_onehot(input logic [GROUP_W-1:0] group);
    group_onehot = {{(MASK_W-1){1'b0}}, 1'b1} << group;
  endfunction

endpackage

// File: rtl/chaining_record_slot.sv
// One record slot: a record_t, its valid flag and a registered mask-full flag.
module chaining_record_slot
  import chaining_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  alloc_en,
  input  record_t               alloc_rec,
  input  logic                  progress_valid,
  input  logic [INST_IDX_W-1:0] progress_instIndex,
  input  logic [GROUP_W-1:0]    progress_group,
  input  logic                  done_valid,
  input  logic [INST_IDX_W-1:0] done_instIndex,
  output logic                  valid,
  output logic                  valid_next,
  output record_t               rec,
  output logic                  mask_full
);

  logic    valid_r;
  logic    mask_full_r;
  record_t rec_r;
  logic    valid_next_s;
  record_t rec_next_s;
  logic    done_hit_s;
  logic    prog_hit_s;

  assign done_hit_s = valid_r & done_valid     & (rec_r.instIndex == done_instIndex);
  assign prog_hit_s = valid_r & progress_valid & (rec_r.instIndex == progress_instIndex);

  // Next slot state: alloc only targets a free slot, done beats progress on a live slot.
  always_comb begin
    valid_next_s = valid_r;
    rec_next_s   = rec_r;
    if (alloc_en) begin
      rec_next_s             = alloc_rec;
      rec_next_s.elementMask = {MASK_W{1'b0}};
      valid_next_s           = 1'b1;
    end else if (done_hit_s) begin
      valid_next_s = 1'b0;
    end else if (prog_hit_s) begin
      rec_next_s.elementMask = rec_r.elementMask | group_onehot(progress_group);
    end else begin
      valid_next_s = valid_r;
    end
  end

  // Slot registers; fields are held after retirement and zeroed only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r     <= 1'b0;
      rec_r       <= '0;
      mask_full_r <= 1'b0;
    end else begin
      valid_r     <= valid_next_s;
      rec_r       <= rec_next_s;
      mask_full_r <= &rec_next_s.elementMask;
    end
  end

  assign valid      = valid_r;
  assign valid_next = valid_next_s;
  assign rec        = rec_r;
  assign mask_full  = mask_full_r;

endmodule

// File: rtl/chaining_record_table_checker.sv
// Protocol checks for the record table.
module chaining_record_table_checker (
  input logic clock,
  input logic reset_n,
  input logic alloc_fire,
  input logic dup_hit,
  input logic done_same
);

  // An allocated index must not already be live unless its holder retires in the same cycle.
  dup_alloc_a: assert property (@(posedge clock) disable iff (!reset_n)
    !(alloc_fire && dup_hit && !done_same));

endmodule

// File: rtl/chaining_record_table.sv
// Record bank driving the chaining write checkers: allocation, progress and retirement.
module chaining_record_table
  import chaining_pkg::*;
#(
  parameter int NUM_RECORDS = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic                          alloc_vd_valid,
  input  logic [VREG_W-1:0]             alloc_vd_bits,
  input  logic                          alloc_vs1_valid,
  input  logic [VREG_W-1:0]             alloc_vs1_bits,
  input  logic [VREG_W-1:0]             alloc_vs2,
  input  logic [INST_IDX_W-1:0]         alloc_instIndex,
  input  logic                          alloc_gather,
  input  logic                          alloc_gather16,
  input  logic                          alloc_onlyRead,
  input  logic                          progress_valid,
  input  logic [INST_IDX_W-1:0]         progress_instIndex,
  input  logic [GROUP_W-1:0]            progress_group,
  input  logic                          done_valid,
  input  logic [INST_IDX_W-1:0]         done_instIndex,
  output logic [NUM_RECORDS-1:0]        record_valid,
  output record_t [NUM_RECORDS-1:0]     record_bits,
  output logic [NUM_RECORDS-1:0]        record_maskFull,
  output logic [$clog2(NUM_RECORDS):0]  occupancy
);

  localparam int CNT_W = $clog2(NUM_RECORDS) + 1;

  logic                   ready_r;
  logic [CNT_W-1:0]       occupancy_r;
  logic                   alloc_fire_s;
  logic [NUM_RECORDS-1:0] free_oh_s;
  logic [NUM_RECORDS-1:0] alloc_en_s;
  logic [NUM_RECORDS-1:0] valid_next_s;
  logic [NUM_RECORDS-1:0] idx_hit_s;
  logic [CNT_W-1:0]       occ_next_s;
  logic                   done_same_s;
  record_t                alloc_rec_s;

  assign alloc_fire_s = alloc_valid & ready_r;

  // Lowest clear bit of the valid vector, as a one-hot.
  assign free_oh_s  = ~record_valid & (record_valid + NUM_RECORDS'(1));
  assign alloc_en_s = alloc_fire_s ? free_oh_s : {NUM_RECORDS{1'b0}};

  // Incoming record; the slot clears the mask on load.
  always_comb begin
    alloc_rec_s             = '0;
    alloc_rec_s.vd_valid    = alloc_vd_valid;
    alloc_rec_s.vd_bits     = alloc_vd_bits;
    alloc_rec_s.vs1_valid   = alloc_vs1_valid;
    alloc_rec_s.vs1_bits    = alloc_vs1_bits;
    alloc_rec_s.vs2         = alloc_vs2;
    alloc_rec_s.instIndex   = alloc_instIndex;
    alloc_rec_s.gather      = alloc_gather;
    alloc_rec_s.gather16    = alloc_gather16;
    alloc_rec_s.onlyRead    = alloc_onlyRead;
    alloc_rec_s.elementMask = {MASK_W{1'b0}};
  end

  for (genvar g = 0; g < NUM_RECORDS; g++) begin : g_slot
    chaining_record_slot u_slot (
      .clock              (clock),
      .reset_n            (reset_n),
      .alloc_en           (alloc_en_s[g]),
      .alloc_rec          (alloc_rec_s),
      .progress_valid     (progress_valid),
      .progress_instIndex (progress_instIndex),
      .progress_group     (progress_group),
      .done_valid         (done_valid),
      .done_instIndex     (done_instIndex),
      .valid              (record_valid[g]),
      .valid_next         (valid_next_s[g]),
      .rec                (record_bits[g]),
      .mask_full          (record_maskFull[g])
    );
    assign idx_hit_s[g] = record_valid[g] & (record_bits[g].instIndex == alloc_instIndex);
  end

  // Popcount of next-cycle valid flags so occupancy can be registered in step with the slots.
  always_comb begin
    occ_next_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_RECORDS; i++) begin
      occ_next_s = occ_next_s + CNT_W'(valid_next_s[i]);
    end
  end

  // Registered handshake and occupancy; a slot freed this cycle is offered from the next one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_r     <= 1'b1;
      occupancy_r <= {CNT_W{1'b0}};
    end else begin
      ready_r     <= ~&valid_next_s;
      occupancy_r <= occ_next_s;
    end
  end

  assign alloc_ready = ready_r;
  assign occupancy   = occupancy_r;
  assign done_same_s = done_valid & (done_instIndex == alloc_instIndex);

  chaining_record_table_checker u_checker (
    .clock      (clock),
    .reset_n    (reset_n),
    .alloc_fire (alloc_fire_s),
    .dup_hit    (|idx_hit_s),
    .done_same  (done_same_s)
  );

endmodule

// File: tb/tb_chaining_record_table.sv
// Self-checking bench: directed scenarios then random traffic against a slot-level reference model.
module tb_chaining_record_table;
  import chaining_pkg::*;

  localparam int NR = 4;

  logic                  clock;
  logic                  reset_n;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic                  alloc_vd_valid;
  logic [VREG_W-1:0]     alloc_vd_bits;
  logic                  alloc_vs1_valid;
  logic [VREG_W-1:0]     alloc_vs1_bits;
  logic [VREG_W-1:0]     alloc_vs2;
  logic [INST_IDX_W-1:0] alloc_instIndex;
  logic                  alloc_gather;
  logic                  alloc_gather16;
  logic                  alloc_onlyRead;
  logic                  progress_valid;
  logic [INST_IDX_W-1:0] progress_instIndex;
  logic [GROUP_W-1:0]    progress_group;
  logic                  done_valid;
  logic [INST_IDX_W-1:0] done_instIndex;
  logic [NR-1:0]         record_valid;
  record_t [NR-1:0]      record_bits;
  logic [NR-1:0]         record_maskFull;
  logic [$clog2(NR):0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one entry per slot, fields held after retirement.
  bit      mv[NR];
  record_t mr[NR];

  chaining_record_table #(.NUM_RECORDS(NR)) dut (
    .clock(clock), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_vd_valid(alloc_vd_valid), .alloc_vd_bits(alloc_vd_bits),
    .alloc_vs1_valid(alloc_vs1_valid), .alloc_vs1_bits(alloc_vs1_bits),
    .alloc_vs2(alloc_vs2), .alloc_instIndex(alloc_instIndex),
    .alloc_gather(alloc_gather), .alloc_gather16(alloc_gather16),
    .alloc_onlyRead(alloc_onlyRead),
    .progress_valid(progress_valid), .progress_instIndex(progress_instIndex),
    .progress_group(progress_group),
    .done_valid(done_valid), .done_instIndex(done_instIndex),
    .record_valid(record_valid), .record_bits(record_bits),
    .record_maskFull(record_maskFull), .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NR-1:0] ev;
    logic [NR-1:0] ef;
    int cnt;
    cnt = 0;
    for (int i = 0; i < NR; i++) begin
      ev[i] = mv[i];
      ef[i] = (mr[i].elementMask == 16'hFFFF);
      cnt += int'(mv[i]);
    end
    chk("record_valid", 64'(record_valid), 64'(ev));
    chk("alloc_ready", 64'(alloc_ready), 64'(cnt < NR));
    chk("occupancy", 64'(occupancy), 64'(cnt));
    chk("record_maskFull", 64'(record_maskFull), 64'(ef));
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("record_bits[%0d]", i), 64'(record_bits[i]), 64'(mr[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
  endtask

  // Advance one clock: the model consumes the inputs present at the edge.
  task automatic cycle();
    bit      nv[NR];
    record_t nr[NR];
    int      cnt;
    int      tgt;
    bit      fire;
    cnt = 0;
    tgt = -1;
    for (int i = 0; i < NR; i++) begin
      cnt += int'(mv[i]);
      if (!mv[i] && tgt < 0) tgt = i;
    end
    fire = alloc_valid && (cnt < NR);
    for (int i = 0; i < NR; i++) begin
      nv[i] = mv[i];
      nr[i] = mr[i];
      if (mv[i] && done_valid && mr[i].instIndex == done_instIndex)
        nv[i] = 1'b0;
      else if (mv[i] && progress_valid && mr[i].instIndex == progress_instIndex)
        nr[i].elementMask[progress_group] = 1'b1;
    end
    if (fire) begin
      nv[tgt]             = 1'b1;
      nr[tgt].vd_valid    = alloc_vd_valid;
      nr[tgt].vd_bits     = alloc_vd_bits;
      nr[tgt].vs1_valid   = alloc_vs1_valid;
      nr[tgt].vs1_bits    = alloc_vs1_bits;
      nr[tgt].vs2         = alloc_vs2;
      nr[tgt].instIndex   = alloc_instIndex;
      nr[tgt].gather      = alloc_gather;
      nr[tgt].gather16    = alloc_gather16;
      nr[tgt].onlyRead    = alloc_onlyRead;
      nr[tgt].elementMask = 16'h0000;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      mv[i] = nv[i];
      mr[i] = nr[i];
    end
    check_all();
  endtask

  task automatic set_alloc(input bit v, input int vd, input int vs1, input int vs2, input int idx);
    alloc_valid     = v;
    alloc_vd_valid  = 1'b1;
    alloc_vd_bits   = VREG_W'(vd);
    alloc_vs1_valid = 1'b1;
    alloc_vs1_bits  = VREG_W'(vs1);
    alloc_vs2       = VREG_W'(vs2);
    alloc_instIndex = INST_IDX_W'(idx);
    alloc_gather    = 1'b0;
    alloc_gather16  = 1'b0;
    alloc_onlyRead  = 1'b0;
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    progress_valid = 1'b0;
    done_valid     = 1'b0;
  endtask

  initial begin
    bit dup;
    reset_n            = 1'b0;
    progress_instIndex = 3'd0;
    progress_group     = 4'd0;
    done_instIndex     = 3'd0;
    set_alloc(1'b0, 0, 0, 0, 0);
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;

    // First allocation lands in slot 0 with an empty mask.
    set_alloc(1'b1, 5, 3, 9, 1);
    cycle();
    chk("first_alloc_valid0", 64'(record_valid[0]), 64'd1);
    chk("first_alloc_mask", 64'(record_bits[0].elementMask), 64'h0000);
    chk("first_alloc_occ", 64'(occupancy), 64'd1);
    idle();

    // Walk all sixteen groups; maskFull rises only after the last one.
    progress_valid     = 1'b1;
    progress_instIndex = 3'd1;
    for (int g = 0; g < 16; g++) begin
      progress_group = GROUP_W'(g);
      cycle();
      if (g == 14) chk("maskfull_early", 64'(record_maskFull[0]), 64'd0);
    end
    chk("maskfull_set", 64'(record_maskFull[0]), 64'd1);
    chk("mask_all_ones", 64'(record_bits[0].elementMask), 64'hFFFF);
    idle();
    done_valid     = 1'b1;
    done_instIndex = 3'd1;
    cycle();
    chk("done_frees_slot0", 64'(record_valid[0]), 64'd0);
    idle();

    // Fill the table, then retire and allocate in the same full cycle.
    for (int k = 0; k < 4; k++) begin
      set_alloc(1'b1, k + 10, k + 20, k + 1, k);
      cycle();
    end
    chk("full_not_ready", 64'(alloc_ready), 64'd0);
    set_alloc(1'b1, 7, 8, 9, 4);
    done_valid     = 1'b1;
    done_instIndex = 3'd2;
    cycle();
    chk("full_alloc_dropped", 64'(record_valid), 64'b1011);
    chk("ready_after_free", 64'(alloc_ready), 64'd1);
    done_valid = 1'b0;
    cycle();
    chk("reuse_slot2_idx", 64'(record_bits[2].instIndex), 64'd4);
    idle();

    // Done beats progress on the same index.
    progress_valid     = 1'b1;
    progress_instIndex = 3'd3;
    progress_group     = 4'd5;
    done_valid         = 1'b1;
    done_instIndex     = 3'd3;
    cycle();
    chk("done_wins_valid3", 64'(record_valid[3]), 64'd0);
    chk("done_wins_mask3", 64'(record_bits[3].elementMask), 64'h0000);
    idle();

    // Unmatched progress and done change nothing.
    progress_valid     = 1'b1;
    progress_instIndex = 3'd6;
    progress_group     = 4'd2;
    cycle();
    idle();
    done_valid     = 1'b1;
    done_instIndex = 3'd7;
    cycle();
    chk("absent_done_occ", 64'(occupancy), 64'd3);
    idle();

    // Asynchronous reset with three live slots.
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 64'(record_valid), 64'd0);
    chk("async_rst_ready", 64'(alloc_ready), 64'd1);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    check_all();
    @(negedge clock);
    reset_n = 1'b1;

    // Random traffic; allocations of an index that stays live are withheld.
    for (int c = 0; c < 400; c++) begin
      set_alloc($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 7));
      alloc_vd_valid     = 1'($urandom_range(0, 1));
      alloc_vs1_valid    = 1'($urandom_range(0, 1));
      alloc_gather       = 1'($urandom_range(0, 1));
      alloc_gather16     = 1'($urandom_range(0, 1));
      alloc_onlyRead     = 1'($urandom_range(0, 1));
      progress_valid     = ($urandom_range(0, 9) < 6);
      progress_instIndex = INST_IDX_W'($urandom_range(0, 7));
      progress_group     = GROUP_W'($urandom_range(0, 15));
      done_valid         = ($urandom_range(0, 9) < 3);
      done_instIndex     = INST_IDX_W'($urandom_range(0, 7));
      dup = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (mv[i] && mr[i].instIndex == alloc_instIndex) dup = 1'b1;
      end
      if (dup && !(done_valid && done_instIndex == alloc_instIndex)) alloc_valid = 1'b0;
      cycle();
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
